// File: rtl/rc.sv
// AND/OR leaf cell. z/w are combinational; a side stage keeps registered
// copies and saturating occupancy counters for debug and monitoring.
module rc #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 x,
    input  logic                 y,
    input  logic                 clear,
    output logic                 z,
    output logic                 w,
    output logic                 z_q,
    output logic                 w_q,
    output logic [CNT_WIDTH-1:0] z_cnt,
    output logic [CNT_WIDTH-1:0] w_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Gate path: no register, independent of clock and reset.
    assign z = x & y;
    assign w = x | y;

    // Observation stage; clear beats increment, counters hold at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            z_q   <= 1'b0;
            w_q   <= 1'b0;
            z_cnt <= '0;
            w_cnt <= '0;
        end else begin
            z_q <= z;
            w_q <= w;
            if (clear) begin
                z_cnt <= '0;
                w_cnt <= '0;
            end else begin
                if (z && (z_cnt != CNT_MAX)) z_cnt <= z_cnt + CNT_WIDTH'(1);
                if (w && (w_cnt != CNT_MAX)) w_cnt <= w_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rc.sv
// Scoreboard bench for rc: a default-width instance and a 2-bit-counter
// instance run side by side from shared stimulus.
module tb_rc;

    logic       clock, reset, x, y, clear;
    logic       z, w, z_q, w_q;
    logic [7:0] z_cnt, w_cnt;
    logic       z2, w2, z_q2, w_q2;
    logic [1:0] z_cnt2, w_cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       zq;
        logic       wq;
        logic [7:0] zc;
        logic [7:0] wc;
        logic [1:0] zc2;
        logic [1:0] wc2;
    } exp_t;

    exp_t sb[$];
    exp_t e, obs;

    // Reference model state
    logic        mzq, mwq;
    int unsigned mz, mw, mz2, mw2;

    rc #(.CNT_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .x(x), .y(y), .clear(clear),
        .z(z), .w(w), .z_q(z_q), .w_q(w_q), .z_cnt(z_cnt), .w_cnt(w_cnt)
    );

    rc #(.CNT_WIDTH(2)) dut2 (
        .clock(clock), .reset(reset), .x(x), .y(y), .clear(clear),
        .z(z2), .w(w2), .z_q(z_q2), .w_q(w_q2), .z_cnt(z_cnt2), .w_cnt(w_cnt2)
    );

    task automatic model_reset();
        mzq = 1'b0; mwq = 1'b0;
        mz = 0; mw = 0; mz2 = 0; mw2 = 0;
    endtask

    // One rising edge; the expected post-edge state is pushed before the edge.
    task automatic tick();
        logic zz, ww;
        zz = x & y;
        ww = x | y;
        if (!reset) begin
            mzq = zz;
            mwq = ww;
            if (clear) begin
                mz = 0; mw = 0; mz2 = 0; mw2 = 0;
            end else begin
                if (zz && mz  < 255) mz++;
                if (ww && mw  < 255) mw++;
                if (zz && mz2 < 3)   mz2++;
                if (ww && mw2 < 3)   mw2++;
            end
        end
        sb.push_back('{mzq, mwq, 8'(mz), 8'(mw), 2'(mz2), 2'(mw2)});
        #5 clock = 1'b1;
        #5 clock = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #3 reset = 1'b0;
        #2;
    endtask

    task automatic test_truth_table();
        logic [1:0] xy;
        logic [1:0] exp_zw;
        for (int i = 0; i < 4; i++) begin
            xy = 2'(i);
            x = xy[1];
            y = xy[0];
            exp_zw = {xy[1] & xy[0], xy[1] | xy[0]};
            #10;
            checks++;
            if ({z, w} !== exp_zw || {z2, w2} !== exp_zw) begin
                errors++;
                $display("FAIL truth_table xy=%b got zw=%b/%b want %b", xy, {z, w}, {z2, w2}, exp_zw);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        obs = '{z_q, w_q, z_cnt, w_cnt, z_cnt2, w_cnt2};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", obs);
        end
    endtask

    task automatic test_latency();
        do_reset();
        x = 1'b1; y = 1'b1;
        #2;
        checks++;
        if ({z_q, w_q} !== 2'b00) begin
            errors++;
            $display("FAIL latency_before_edge got %b want 00", {z_q, w_q});
        end
        tick();
        e = sb.pop_front();
        obs = '{z_q, w_q, z_cnt, w_cnt, z_cnt2, w_cnt2};
        checks++;
        if (obs !== e || {z_q, w_q} !== 2'b11) begin
            errors++;
            $display("FAIL latency_11 got %h want %h", obs, e);
        end
        x = 1'b1; y = 1'b0;
        tick();
        e = sb.pop_front();
        obs = '{z_q, w_q, z_cnt, w_cnt, z_cnt2, w_cnt2};
        checks++;
        if (obs !== e || {z_q, w_q} !== 2'b01) begin
            errors++;
            $display("FAIL latency_10 got %h want %h", obs, e);
        end
    endtask

    task automatic test_counting();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            x = (i >= 3); y = 1'b1;
            tick();
            e = sb.pop_front();
            obs = '{z_q, w_q, z_cnt, w_cnt, z_cnt2, w_cnt2};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL counting_step%0d got %h want %h", i, obs, e);
            end
        end
        checks++;
        if (z_cnt !== 8'd2 || w_cnt !== 8'd5) begin
            errors++;
            $display("FAIL counting_total got z_cnt=%0d w_cnt=%0d want 2 5", z_cnt, w_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        x = 1'b1; y = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e = sb.pop_front();
            obs = '{z_q, w_q, z_cnt, w_cnt, z_cnt2, w_cnt2};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL saturation_step%0d got %h want %h", i, obs, e);
            end
            if (i == 5 || i == 7) begin
                checks++;
                if (z_cnt2 !== 2'd3 || w_cnt2 !== 2'd3) begin
                    errors++;
                    $display("FAIL saturation_hold%0d got %0d %0d want 3 3", i, z_cnt2, w_cnt2);
                end
            end
        end
    endtask

    task automatic test_clear_priority();
        do_reset();
        x = 1'b1; y = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            void'(sb.pop_front());
        end
        checks++;
        if (z_cnt !== 8'd4 || w_cnt !== 8'd4) begin
            errors++;
            $display("FAIL clear_setup got %0d %0d want 4 4", z_cnt, w_cnt);
        end
        clear = 1'b1;
        tick();
        e = sb.pop_front();
        obs = '{z_q, w_q, z_cnt, w_cnt, z_cnt2, w_cnt2};
        checks++;
        if (obs !== e || z_cnt !== 8'd0 || w_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clear_wins got %h want %h", obs, e);
        end
        clear = 1'b0;
        tick();
        e = sb.pop_front();
        obs = '{z_q, w_q, z_cnt, w_cnt, z_cnt2, w_cnt2};
        checks++;
        if (obs !== e || z_cnt !== 8'd1 || w_cnt !== 8'd1) begin
            errors++;
            $display("FAIL clear_release got %h want %h", obs, e);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        x = 1'b0; y = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            void'(sb.pop_front());
        end
        #2 reset = 1'b1;
        model_reset();
        #1;
        obs = '{z_q, w_q, z_cnt, w_cnt, z_cnt2, w_cnt2};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_reset_immediate got %h want 0", obs);
        end
        for (int i = 0; i < 4; i++) begin
            x = i[1]; y = i[0];
            #2;
            checks++;
            if (z !== (x & y) || w !== (x | y)) begin
                errors++;
                $display("FAIL zw_during_reset x=%b y=%b got %b%b", x, y, z, w);
            end
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        e = sb.pop_front();
        obs = '{z_q, w_q, z_cnt, w_cnt, z_cnt2, w_cnt2};
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_holds got %h want %h", obs, e);
        end
        reset = 1'b0;
        x = 1'b1; y = 1'b1;
        #2;
        tick();
        e = sb.pop_front();
        obs = '{z_q, w_q, z_cnt, w_cnt, z_cnt2, w_cnt2};
        checks++;
        if (obs !== e || z_cnt !== 8'd1) begin
            errors++;
            $display("FAIL first_edge_after_reset got %h want %h", obs, e);
        end
    endtask

    initial begin
        clock = 1'b0; reset = 1'b0; x = 1'b0; y = 1'b0; clear = 1'b0;
        model_reset();
        test_truth_table();
        test_reset();
        test_latency();
        test_counting();
        test_saturation();
        test_clear_priority();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc.md
# rc

Combinational logic cell with a registered observation stage. It produces the AND (`z`) and OR (`w`) of two single-bit inputs with zero clock latency. It also keeps one-cycle-registered copies of both results and saturating occupancy counters for each. It sits as a leaf cell beside the other basic gate cells; the registered side serves debug and monitoring only and never affects `z`/`w`.

## Interface

Parameters:
- `CNT_WIDTH`, default 8: width of each occupancy counter; legal range 2..32.

Ports:
- One clock; reset is asynchronous and active-high.
- `clock`  in  1  rising-edge clock for the registered stage only.
- `reset`  in  1  asynchronous, active-high; clears every register immediately.
- `x`  in  1  operand A.
- `y`  in  1  operand B.
- `clear`  in  1  synchronous counter clear, active-high.
- `z`  out  1  combinational `x AND y`.
- `w`  out  1  combinational `x OR y`.
- `z_q`  out  1  `z` registered one cycle.
- `w_q`  out  1  `w` registered one cycle.
- `z_cnt`  out  CNT_WIDTH  number of rising edges at which `z` was 1; saturating.
- `w_cnt`  out  CNT_WIDTH  number of rising edges at which `w` was 1; saturating.

## Operation

- Truth table for `z` and `w`, as `x y -> z w`:
  - 0 0 -> 0 0
  - 0 1 -> 0 1
  - 1 0 -> 0 1
  - 1 1 -> 1 1
- `z` and `w` are purely combinational.
  - They depend only on `x` and `y`.
  - They are valid with `clock` stopped and with `reset` asserted, floating or X.
  - No register sits in this path.
- Registered stage, at each rising `clock` edge when `reset`=0:
  - `z_q` <= current `z`; `w_q` <= current `w`.
  - If `clear`=1: `z_cnt` <= 0 and `w_cnt` <= 0. Clear wins over a simultaneous increment.
  - Otherwise `z_cnt` increments by 1 when `z`=1 and holds when `z`=0. Same rule for `w_cnt` with `w`.
  - Saturation: a counter at all-ones (2^CNT_WIDTH − 1) holds. It never wraps to 0.
- Invariant: at any time `z_cnt` <= `w_cnt`, because `z` implies `w`. Both counters start and clear together.
- X/Z on `x` or `y` yields X on `z`/`w`, with no masking. Inputs are registered as-is, with no synchroniser.

## Timing

- `z`/`w`: zero cycles, one gate-level propagation delay. Values must be settled well within 10 time units of an input change.
- `z_q`/`w_q`: one cycle latency. They reflect `z`/`w` as sampled at the last rising edge.
- Counters update at the same edge as `z_q`/`w_q`. A value sampled at edge N is visible after edge N.
- Reset, asynchronous:
  - Asserting `reset` forces `z_q`=0, `w_q`=0, `z_cnt`=0, `w_cnt`=0 immediately, without waiting for a clock edge.
  - While `reset` is high, no register updates.
  - The first edge after deassertion samples normally.
- Reset mid-count drops counters to 0 at once. There is no partial or delayed clear.
- `clear` during `reset` has no additional effect.

## Test plan

- Truth table, clock idle, reset unused: apply `x y` = 00, 01, 10, 11 with 10 time units each. Require `z w` = 00, 01, 01, 11 respectively.
- Latency: with `reset` released, set `x y`=11 and apply one rising edge. Require `z_q`=1 and `w_q`=1 after that edge and not before. Then set `x y`=10 and apply an edge. Require `z_q`=0 and `w_q`=1.
- Counting: after reset, hold `x y`=01 for 3 edges, then 11 for 2 edges. Require `z_cnt`=2 and `w_cnt`=5.
- Saturation: with CNT_WIDTH=2, hold `x y`=11 for 6 edges. Require `z_cnt`=3 and `w_cnt`=3, then both still 3 after 2 more edges.
- Clear priority: with counters at 4, assert `clear` with `x y`=11 for one edge. Require both counters 0 after the edge. Release `clear` and apply 1 edge; require both counters 1.
- Asynchronous reset: with counters nonzero, assert `reset` between clock edges. Require all registered outputs 0 before the next edge. Require `z`/`w` to still follow `x`/`y` throughout.
